gpu_mem_controller: RTL and testbench

//  Arbitrates NUM_USERS memory requesters (warp fetchers or per-thread LSUs) onto NUM_CHANNELS memory channels.

---
 rtl/gpu_mem_controller_pkg.sv | 16 +
 rtl/gpu_mem_controller_if.sv | 41 ++++
 rtl/gpu_mem_controller_channel.sv | 83 ++++++++
 rtl/gpu_mem_controller.sv | 157 +++++++++++++++
 tb/tb_gpu_mem_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_mem_controller_pkg.sv
// Shared types and default widths for the GPU memory controller slice.
package gpu_mem_controller_pkg;

  localparam int MEM_DATA_WIDTH    = 32;
  localparam int MEM_ADDR_WIDTH    = 32;
  localparam int MEM_NUM_USERS     = 8;
  localparam int MEM_NUM_CHANNELS  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE
  } mem_ch_state_t;

endpackage

// File: rtl/gpu_mem_controller_if.sv
// User-side and memory-side buses of the GPU memory controller.
// slave is the controller's view; master is the environment's view.
interface gpu_mem_controller_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_USERS    = 8,
  parameter int NUM_CHANNELS = 4
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [NUM_USERS-1:0]                    req_ready;
  logic [NUM_USERS-1:0]                    req_valid;
  logic [NUM_USERS-1:0][BYTES-1:0]         req_we;
  logic [NUM_USERS-1:0][ADDR_WIDTH-1:0]    req_addr;
  logic [NUM_USERS-1:0][DATA_WIDTH-1:0]    req_data;
  logic [NUM_USERS-1:0]                    req_resp_valid;
  logic [NUM_USERS-1:0][DATA_WIDTH-1:0]    req_resp_data;

  logic [NUM_CHANNELS-1:0]                 mem_ready;
  logic [NUM_CHANNELS-1:0]                 mem_valid;
  logic [NUM_CHANNELS-1:0][BYTES-1:0]      mem_we;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_addr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_data;
  logic [NUM_CHANNELS-1:0]                 mem_resp_valid;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_resp_data;

  modport slave (
    output req_ready, req_resp_valid, req_resp_data,
    output mem_valid, mem_we, mem_addr, mem_data,
    input  req_valid, req_we, req_addr, req_data,
    input  mem_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    input  req_ready, req_resp_valid, req_resp_data,
    input  mem_valid, mem_we, mem_addr, mem_data,
    output req_valid, req_we, req_addr, req_data,
    output mem_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/gpu_mem_controller_channel.sv
// One memory channel: IDLE->ISSUE->WAIT->RELEASE FSM holding the latched request
// of the user it claimed.
module gpu_mem_channel
  import gpu_mem_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int UW         = 3,
  parameter int BYTES      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  grant,
  input  logic [UW-1:0]         grant_user,
  input  logic [ADDR_WIDTH-1:0] grant_addr,
  input  logic [DATA_WIDTH-1:0] grant_data,
  input  logic [BYTES-1:0]      grant_we,
  input  logic                  user_valid,
  input  logic                  mem_ready,
  input  logic                  mem_resp_valid,
  output logic                  idle,
  output logic [UW-1:0]         user,
  output logic                  resp_fire,
  output logic                  release_fire,
  output logic                  mem_valid,
  output logic [BYTES-1:0]      mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data
);

  mem_ch_state_t state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      user     <= '0;
      mem_we   <= '0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant) begin
        user     <= grant_user;
        mem_we   <= grant_we;
        mem_addr <= grant_addr;
        mem_data <= grant_data;
      end
    end
  end

  // RELEASE waits for the user to drop req_valid so a held request is not served twice.
  always_comb begin
    state_d      = state_q;
    mem_valid    = 1'b0;
    resp_fire    = 1'b0;
    release_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) state_d = ISSUE;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          resp_fire = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (!user_valid) begin
          release_fire = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle = (state_q == IDLE);

endmodule

// File: rtl/gpu_mem_controller.sv
// Arbitrates NUM_USERS requesters onto NUM_CHANNELS memory channels.
// Define MEMCTRL_RR_ARB_EN for per-channel round-robin; otherwise lowest user index wins.
module gpu_mem_controller
  import gpu_mem_controller_pkg::*;
#(
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int NUM_USERS    = MEM_NUM_USERS,
  parameter int NUM_CHANNELS = MEM_NUM_CHANNELS
) (
  input  logic                 clk,
  input  logic                 reset,
  gpu_mem_controller_if.slave  bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int UW    = $clog2(NUM_USERS);

  logic [NUM_USERS-1:0]                    claimed;
  logic [NUM_USERS-1:0]                    taken;
  logic [NUM_USERS-1:0]                    avail;
  logic [NUM_USERS-1:0]                    resp_valid_q;
  logic [NUM_USERS-1:0][DATA_WIDTH-1:0]    resp_data_q;

  logic [NUM_CHANNELS-1:0]                 grant;
  logic [NUM_CHANNELS-1:0][UW-1:0]         grant_user;
  logic [NUM_CHANNELS-1:0]                 ch_idle;
  logic [NUM_CHANNELS-1:0][UW-1:0]         ch_user;
  logic [NUM_CHANNELS-1:0]                 ch_user_valid;
  logic [NUM_CHANNELS-1:0]                 ch_resp_fire;
  logic [NUM_CHANNELS-1:0]                 ch_release_fire;
  logic [NUM_CHANNELS-1:0]                 ch_mem_valid;
  logic [NUM_CHANNELS-1:0][BYTES-1:0]      ch_mem_we;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] ch_mem_addr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_mem_data;
  int                                      search_start [NUM_CHANNELS];

  function automatic logic [UW-1:0] pick_user(input logic [NUM_USERS-1:0] cand, input int start);
    logic [UW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_USERS; k++) begin
      idx = (start + k) % NUM_USERS;
      if (!found && cand[idx]) begin
        sel   = UW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

`ifdef MEMCTRL_RR_ARB_EN
  logic [NUM_CHANNELS-1:0][UW-1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (grant[c]) rr_ptr[c] <= grant_user[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      search_start[c] = (int'(rr_ptr[c]) + 1) % NUM_USERS;
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      search_start[c] = 0;
  end
`endif

  // Lower-index channels pick first; their picks are masked out for the channels after them.
  always_comb begin
    taken      = '0;
    avail      = '0;
    grant      = '0;
    grant_user = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      avail = bus.req_valid & ~claimed & ~taken;
      if (ch_idle[c] && (avail != '0)) begin
        grant[c]             = 1'b1;
        grant_user[c]        = pick_user(avail, search_start[c]);
        taken[grant_user[c]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      claimed <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (ch_release_fire[c]) claimed[ch_user[c]] <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (grant[c]) claimed[grant_user[c]] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (ch_resp_fire[c]) begin
          resp_valid_q[ch_user[c]] <= 1'b1;
          resp_data_q[ch_user[c]]  <= bus.mem_resp_data[c];
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign ch_user_valid[c] = bus.req_valid[ch_user[c]];

    gpu_mem_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .UW         (UW),
      .BYTES      (BYTES)
    ) u_channel (
      .clk            (clk),
      .reset          (reset),
      .grant          (grant[c]),
      .grant_user     (grant_user[c]),
      .grant_addr     (bus.req_addr[grant_user[c]]),
      .grant_data     (bus.req_data[grant_user[c]]),
      .grant_we       (bus.req_we[grant_user[c]]),
      .user_valid     (ch_user_valid[c]),
      .mem_ready      (bus.mem_ready[c]),
      .mem_resp_valid (bus.mem_resp_valid[c]),
      .idle           (ch_idle[c]),
      .user           (ch_user[c]),
      .resp_fire      (ch_resp_fire[c]),
      .release_fire   (ch_release_fire[c]),
      .mem_valid      (ch_mem_valid[c]),
      .mem_we         (ch_mem_we[c]),
      .mem_addr       (ch_mem_addr[c]),
      .mem_data       (ch_mem_data[c])
    );
  end

  assign bus.req_ready      = ~claimed;
  assign bus.req_resp_valid = resp_valid_q;
  assign bus.req_resp_data  = resp_data_q;
  assign bus.mem_valid      = ch_mem_valid;
  assign bus.mem_we         = ch_mem_we;
  assign bus.mem_addr       = ch_mem_addr;
  assign bus.mem_data       = ch_mem_data;

endmodule

// File: tb/tb_gpu_mem_controller.sv
// Scoreboarded bench for gpu_mem_controller: user drivers push expected responses,
// a memory responder serves channels, and a monitor checks every response pulse.
module tb_gpu_mem_controller;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NU = 8;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gpu_mem_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_USERS(NU), .NUM_CHANNELS(NC)) bus ();

  gpu_mem_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_USERS(NU), .NUM_CHANNELS(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q [NU][$];
  exp_t        mon_e;
  bit          pend_valid  [NU];
  bit          pend_issued [NU];
  logic [31:0] pend_addr   [NU];
  logic [31:0] pend_data   [NU];
  logic [3:0]  pend_we     [NU];
  logic [31:0] model_mem [int unsigned];
  logic [31:0] phys_mem  [int unsigned];
  bit          force_ready_low = 1'b0;
  bit          spurious_en = 1'b1;
  int          last_issue_ch = -1;
  bit          outst [NC];
  int          dly   [NC];
  logic [31:0] oaddr [NC];
  logic [3:0]  owe   [NC];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one request for user u at the current negedge, waits for its pulse,
  // optionally holds req_valid high, then drops it and leaves a two-cycle gap.
  task automatic applyStimulus(input int u, input logic [31:0] addr, input logic [3:0] we,
                               input logic [31:0] data, input int hold);
    exp_t e;
    int   n;
    checkOutput($sformatf("ready_before_issue_u%0d", u), 32'(bus.req_ready[u]), 32'd1);
    e.is_read = (we == 4'h0);
    if (we == 4'h0) begin
      e.data = model_read(addr);
    end else begin
      model_mem[addr] = merge(model_read(addr), data, we);
      e.data = 32'h0;
    end
    exp_q[u].push_back(e);
    pend_addr[u]      = addr;
    pend_data[u]      = data;
    pend_we[u]        = we;
    pend_issued[u]    = 1'b0;
    pend_valid[u]     = 1'b1;
    bus.req_we[u]     = we;
    bus.req_addr[u]   = addr;
    bus.req_data[u]   = data;
    bus.req_valid[u]  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_resp_valid[u] && n < 300);
    if (!bus.req_resp_valid[u])
      checkOutput($sformatf("resp_timeout_u%0d", u), 32'd0, 32'd1);
    pend_valid[u] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_ready_low_u%0d", u), 32'(bus.req_ready[u]), 32'd0);
    end
    bus.req_valid[u] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: random ready, 0-3 cycle response delay, occasional stray response pulses.
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (!reset) begin
        bus.mem_ready[c]      = 1'b0;
        bus.mem_resp_valid[c] = 1'b0;
        bus.mem_resp_data[c]  = '0;
        outst[c]              = 1'b0;
        continue;
      end
      if (outst[c]) begin
        if (dly[c] == 0) begin
          bus.mem_resp_valid[c] = 1'b1;
          bus.mem_resp_data[c]  = (owe[c] == 4'h0) ? phys_read(oaddr[c]) : $urandom;
          outst[c]              = 1'b0;
        end else begin
          dly[c]--;
          bus.mem_resp_valid[c] = 1'b0;
        end
      end else begin
        bus.mem_resp_valid[c] = spurious_en && ($urandom_range(0, 9) == 0);
        bus.mem_resp_data[c]  = $urandom;
      end
      bus.mem_ready[c] = force_ready_low ? 1'b0 : ($urandom_range(0, 9) < 7);
      if (bus.mem_valid[c] && bus.mem_ready[c]) begin
        automatic int found = -1;
        if (outst[c]) checkOutput($sformatf("issue_while_waiting_ch%0d", c), 32'd1, 32'd0);
        for (int u = 0; u < NU; u++)
          if (found < 0 && pend_valid[u] && !pend_issued[u] && pend_addr[u] == bus.mem_addr[c])
            found = u;
        if (found < 0) begin
          checkOutput($sformatf("unexpected_issue_ch%0d", c), bus.mem_addr[c], 32'hFFFFFFFF);
        end else begin
          checkOutput($sformatf("issue_we_u%0d", found), 32'(bus.mem_we[c]), 32'(pend_we[found]));
          if (pend_we[found] != 4'h0) begin
            checkOutput($sformatf("issue_data_u%0d", found), bus.mem_data[c], pend_data[found]);
            phys_mem[bus.mem_addr[c]] = merge(phys_read(bus.mem_addr[c]), bus.mem_data[c], bus.mem_we[c]);
          end
          pend_issued[found] = 1'b1;
        end
        last_issue_ch = c;
        outst[c]      = 1'b1;
        dly[c]        = $urandom_range(0, 3);
        oaddr[c]      = bus.mem_addr[c];
        owe[c]        = bus.mem_we[c];
      end
    end
  end

  // Monitor: every response pulse must match the oldest outstanding expectation of that user.
  always @(negedge clk) begin
    if (reset) begin
      for (int u = 0; u < NU; u++) begin
        if (bus.req_resp_valid[u]) begin
          if (exp_q[u].size() == 0) begin
            checkOutput($sformatf("spurious_resp_u%0d", u), 32'd1, 32'd0);
          end else begin
            mon_e = exp_q[u].pop_front();
            if (mon_e.is_read)
              checkOutput($sformatf("read_data_u%0d", u), bus.req_resp_data[u], mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    for (int u = 0; u < NU; u++) begin
      pend_valid[u]  = 1'b0;
      pend_issued[u] = 1'b0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'hFF);
    checkOutput("rst_req_resp_valid", 32'(bus.req_resp_valid), 32'h0);
    checkOutput("rst_req_resp_data", 32'(|bus.req_resp_data), 32'h0);
    checkOutput("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    checkOutput("rst_mem_addr", 32'(|bus.mem_addr), 32'h0);
    checkOutput("rst_mem_we_data", 32'(|{bus.mem_we, bus.mem_data}), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    model_mem[32'h40] = 32'hDEADBEEF;
    phys_mem[32'h40]  = 32'hDEADBEEF;
    applyStimulus(3, 32'h40, 4'h0, 32'h0, 0);
    checkOutput("single_read_channel", 32'(last_issue_ch), 32'd0);

    applyStimulus(1, 32'h104, 4'b0011, 32'h00001234, 0);
    applyStimulus(1, 32'h104, 4'h0, 32'h0, 0);

    for (int u = 0; u < NU; u++) begin
      fork
        automatic int uu = u;
        applyStimulus(uu, (32'(uu) << 8) | 32'h10, 4'h0, 32'h0, 0);
      join_none
    end
    @(negedge clk);
    checkOutput("contention_claims", 32'($countones(~bus.req_ready)), 32'd4);
    checkOutput("contention_mem_valid", 32'(bus.mem_valid), 32'hF);
`ifndef MEMCTRL_RR_ARB_EN
    checkOutput("contention_fixed_prio", 32'(bus.req_ready), 32'hF0);
`endif
    wait fork;

    force_ready_low = 1'b1;
    fork
      applyStimulus(5, 32'h520, 4'h0, 32'h0, 0);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("backpressure_mem_valid", 32'(bus.mem_valid[0]), 32'd1);
      checkOutput("backpressure_addr", bus.mem_addr[0], 32'h520);
      checkOutput("backpressure_no_resp", 32'(bus.req_resp_valid), 32'h0);
    end
    force_ready_low = 1'b0;
    wait fork;

    applyStimulus(2, 32'h230, 4'h0, 32'h0, 6);

    for (int u = 0; u < NU; u++) begin
      fork
        automatic int uu = u;
        begin
          for (int k = 0; k < 15; k++) begin
            automatic logic [3:0]  we   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            automatic logic [31:0] addr = (32'(uu) << 8) | (32'($urandom_range(0, 7)) << 2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(uu, addr, we, $urandom, $urandom_range(0, 2));
          end
        end
      join_none
    end
    wait fork;

    repeat (5) @(negedge clk);
    for (int u = 0; u < NU; u++)
      checkOutput($sformatf("leftover_expect_u%0d", u), 32'(exp_q[u].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
